// File: rtl/spi_ctrl.sv
// spi_ctrl: SPI initiator with a 1-byte tx buffer and strobed rx byte.
// Drives sck/csn/sdi from the system clock; captures sdo MSB first.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   tx_data/tx_stb  byte to send, accepted when tx_stb && tx_ready
//   tx_ready        tx buffer empty
//   rx_data/rx_stb  received byte, valid on the rx_stb pulse
//   busy            FSM active or tx buffer occupied
//   spi_sck/csn/sdi controller-driven bus pins (sck idles low)
//   spi_sdo         peripheral data, sampled on the sck falling edge
//
// Parameters: CLK_DIV clocks per sck half-period, CSN_IDLE min csn-high
// clocks between frames.
// Build option: define SPI_CTRL_SDO_SYNC_EN to pass spi_sdo through a
// 2-FF synchronizer before capture (needs CLK_DIV >= 3).

module spi_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CSN_IDLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_stb,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_stb,
  output logic       busy,
  output logic       spi_sck,
  output logic       spi_csn,
  output logic       spi_sdi,
  input  logic       spi_sdo
);

  localparam int MAXC = (CLK_DIV > CSN_IDLE) ? CLK_DIV : CSN_IDLE;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PH_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(CSN_IDLE - 1);

  if (CLK_DIV < 1) begin : g_chk_div
    $error("spi_ctrl: CLK_DIV must be >= 1");
  end
  if (CSN_IDLE < 1) begin : g_chk_gap
    $error("spi_ctrl: CSN_IDLE must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    TAIL,
    GAP
  } state_t;

  state_t state;
  state_t nxt;

  logic [CW-1:0] div;
  logic [CW-1:0] div_val;
  logic          div_ld;
  logic          div_zero;

  logic [7:0] buf_q;
  logic       buf_valid;
  logic [7:0] tx_sh;
  logic [7:0] rx_sh;
  logic [3:0] bit_cnt;
  logic       stb_pend;

  logic load;
  logic fall;
  logic last;
  logic sdo_s;

  logic sck_q;
  logic csn_q;

`ifdef SPI_CTRL_SDO_SYNC_EN
  if (CLK_DIV < 3) begin : g_chk_sync
    $error("spi_ctrl: SPI_CTRL_SDO_SYNC_EN needs CLK_DIV >= 3");
  end

  logic sdo_meta;
  logic sdo_sync;

  // Capture sees sdo as it was two clocks before the sck fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdo_meta <= 1'b0;
      sdo_sync <= 1'b0;
    end else begin
      sdo_meta <= spi_sdo;
      sdo_sync <= sdo_meta;
    end
  end

  assign sdo_s = sdo_sync;
`else
  assign sdo_s = spi_sdo;
`endif

  assign div_zero = (div == '0);
  assign last     = (bit_cnt == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Each phase reloads div so it lasts exactly its clock count.
  always_comb begin
    nxt     = state;
    div_ld  = 1'b0;
    div_val = PH_LD;
    load    = 1'b0;
    fall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (buf_valid) begin
          nxt    = SETUP;
          load   = 1'b1;
          div_ld = 1'b1;
        end
      end
      SETUP: begin
        if (div_zero) begin
          nxt    = HIGH;
          div_ld = 1'b1;
        end
      end
      HIGH: begin
        if (div_zero) begin
          nxt    = LOW;
          fall   = 1'b1;
          div_ld = 1'b1;
        end
      end
      LOW: begin
        if (div_zero) begin
          div_ld = 1'b1;
          if (!last) begin
            nxt = HIGH;
          end else if (buf_valid) begin
            // Back-to-back byte: csn stays low.
            nxt  = SETUP;
            load = 1'b1;
          end else begin
            nxt = TAIL;
          end
        end
      end
      TAIL: begin
        if (div_zero) begin
          nxt     = GAP;
          div_ld  = 1'b1;
          div_val = GAP_LD;
        end
      end
      GAP: begin
        if (div_zero) begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // Bus pins follow the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q <= 1'b0;
      csn_q <= 1'b1;
    end else begin
      sck_q <= (nxt == HIGH);
      csn_q <= (nxt == IDLE) || (nxt == GAP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div       <= '0;
      buf_q     <= 8'h00;
      buf_valid <= 1'b0;
      tx_sh     <= 8'h00;
      rx_sh     <= 8'h00;
      bit_cnt   <= 4'd0;
      stb_pend  <= 1'b0;
      rx_stb    <= 1'b0;
      rx_data   <= 8'h00;
    end else begin
      if (div_ld) begin
        div <= div_val;
      end else if (!div_zero) begin
        div <= div - CW'(1);
      end

      if (load) begin
        buf_valid <= 1'b0;
        tx_sh     <= buf_q;
        bit_cnt   <= 4'd0;
      end

      // Never coincides with load: tx_ready is low while buf_valid.
      if (tx_stb && !buf_valid) begin
        buf_q     <= tx_data;
        buf_valid <= 1'b1;
      end

      if (fall) begin
        tx_sh   <= {tx_sh[6:0], 1'b0};
        rx_sh   <= {rx_sh[6:0], sdo_s};
        bit_cnt <= bit_cnt + 4'd1;
      end

      // Byte completes on the 8th fall; strobe it a cycle later.
      stb_pend <= fall && (bit_cnt == 4'd7);
      rx_stb   <= stb_pend;
      if (stb_pend) begin
        rx_data <= rx_sh;
      end
    end
  end

  assign tx_ready = !buf_valid;
  assign busy     = (state != IDLE) || buf_valid;
  assign spi_sck  = sck_q;
  assign spi_csn  = csn_q;
  assign spi_sdi  = tx_sh[7];

endmodule

// File: tb/tb_spi_ctrl.sv
// tb_spi_ctrl: directed bench for spi_ctrl with a peripheral model
// and scoreboard queues for sdi bytes and rx bytes.

module tb_spi_ctrl;

`ifdef SPI_CTRL_SDO_SYNC_EN
  localparam int CD = 4;
`else
  localparam int CD = 2;
`endif
  localparam int CI = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_stb;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       busy;
  logic       spi_sck;
  logic       spi_csn;
  logic       spi_sdi;
  logic       spi_sdo;

  spi_ctrl #(
    .CLK_DIV (CD),
    .CSN_IDLE(CI)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_data (tx_data),
    .tx_stb  (tx_stb),
    .tx_ready(tx_ready),
    .rx_data (rx_data),
    .rx_stb  (rx_stb),
    .busy    (busy),
    .spi_sck (spi_sck),
    .spi_csn (spi_csn),
    .spi_sdi (spi_sdi),
    .spi_sdo (spi_sdo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int cyc       = 0;
  int pcnt      = 0;
  int n_stb     = 0;
  int last_stb  = 0;
  int stb_gap   = 0;
  int csn_cnt   = 0;
  int csn_low   = 0;
  int csn_falls = 0;
  int csn_rises = 0;
  int falls     = 0;
  int rst_sck   = 0;

  logic       prev_sck = 1'b0;
  logic       prev_csn = 1'b1;
  logic [7:0] cur = 8'h00;
  logic [7:0] sin = 8'h00;

  logic [7:0] rep_q[$];
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Peripheral model and output monitor, evaluated every negedge.
  task automatic mon();
    cyc++;
    if (prev_csn && !spi_csn) begin
      pcnt = 0;
      csn_falls++;
    end
    if (!spi_csn) csn_cnt++;
    if (!prev_csn && spi_csn) begin
      csn_low = csn_cnt;
      csn_cnt = 0;
      csn_rises++;
    end
    if (!prev_sck && spi_sck && !spi_csn) begin
      if (pcnt == 0) begin
        cur = (rep_q.size() > 0) ? rep_q.pop_front() : 8'h00;
      end
      spi_sdo = cur[7-pcnt];
      sin = {sin[6:0], spi_sdi};
      pcnt++;
      if (pcnt == 8) begin
        pcnt = 0;
        chk("sdi_qsize", 32'(exp_tx_q.size() > 0), 32'd1);
        if (exp_tx_q.size() > 0) begin
          chk("sdi_byte", 32'(sin), 32'(exp_tx_q.pop_front()));
        end
      end
    end
    if (prev_sck && !spi_sck) falls++;
    if (rst && spi_sck) rst_sck++;
    if (rx_stb) begin
      chk("rx_qsize", 32'(exp_rx_q.size() > 0), 32'd1);
      if (exp_rx_q.size() > 0) begin
        chk("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
      end
      stb_gap  = cyc - last_stb;
      last_stb = cyc;
      n_stb++;
    end
    prev_sck = spi_sck;
    prev_csn = spi_csn;
  endtask

  task automatic tick();
    @(negedge clk);
    mon();
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data = d;
    tx_stb  = 1'b1;
    tick();
    tx_stb  = 1'b0;
  endtask

  task automatic wait_frame_end(input int budget);
    int r0 = csn_rises;
    int n  = 0;
    while (csn_rises == r0 && n < budget) begin
      tick();
      n++;
    end
    chk("frame_end_timeout", 32'(csn_rises != r0), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
    repeat (4) tick();
  endtask

  logic [7:0] bp_tx [3];
  logic [7:0] bp_rx [3];

  initial begin
    int s0;
    int f0;
    int idx;
    int stall;
    int n;

    rst     = 1'b1;
    tx_data = 8'h00;
    tx_stb  = 1'b0;
    spi_sdo = 1'b0;
    bp_tx   = '{8'h11, 8'h22, 8'h33};
    bp_rx   = '{8'h9A, 8'hBC, 8'hDE};

    // Reset
    repeat (3) tick();
    chk("rst_csn_held", 32'(spi_csn), 32'd1);
    chk("rst_sck_edges", 32'(rst_sck), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_csn", 32'(spi_csn), 32'd1);
    chk("rst_sdi", 32'(spi_sdi), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);
    chk("rst_rx_stb", 32'(rx_stb), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_no_falls", 32'(falls), 32'd0);

    // Single byte A5 / 3C
    rep_q.push_back(8'h3C);
    exp_tx_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    s0 = n_stb;
    send(8'hA5);
    chk("hs1_csn", 32'(spi_csn), 32'd1);
    chk("hs1_tx_ready", 32'(tx_ready), 32'd0);
    chk("hs1_busy", 32'(busy), 32'd1);
    tick();
    chk("hs2_csn", 32'(spi_csn), 32'd0);
    chk("hs2_sdi_msb", 32'(spi_sdi), 32'd1);
    wait_frame_end(400);
    chk("single_csn_low", 32'(csn_low), 32'(18 * CD));
    wait_idle(400);
    chk("single_stb_cnt", 32'(n_stb - s0), 32'd1);
    chk("single_sdi_end", 32'(spi_sdi), 32'd0);

    // Streaming 01,FE / 55,AA
    rep_q.push_back(8'h55);
    rep_q.push_back(8'hAA);
    exp_tx_q.push_back(8'h01);
    exp_tx_q.push_back(8'hFE);
    exp_rx_q.push_back(8'h55);
    exp_rx_q.push_back(8'hAA);
    s0 = n_stb;
    f0 = csn_falls;
    send(8'h01);
    send(8'hFE);
    chk("stream_fe_in_frame", 32'(spi_csn), 32'd0);
    wait_frame_end(800);
    chk("stream_csn_low", 32'(csn_low), 32'(35 * CD));
    chk("stream_csn_falls", 32'(csn_falls - f0), 32'd1);
    wait_idle(400);
    chk("stream_stb_cnt", 32'(n_stb - s0), 32'd2);
    chk("stream_stb_gap", 32'(stb_gap), 32'(17 * CD));

    // Back-pressure: tx_stb held for 3 bytes
    for (int i = 0; i < 3; i++) begin
      rep_q.push_back(bp_rx[i]);
      exp_tx_q.push_back(bp_tx[i]);
      exp_rx_q.push_back(bp_rx[i]);
    end
    s0    = n_stb;
    idx   = 0;
    stall = 0;
    n     = 0;
    tx_stb = 1'b1;
    while (idx < 3 && n < 2000) begin
      tx_data = bp_tx[idx];
      if (tx_ready) idx++;
      else stall++;
      tick();
      n++;
    end
    tx_stb = 1'b0;
    chk("bp_all_accepted", 32'(idx), 32'd3);
    chk("bp_stalled", 32'(stall > 0), 32'd1);
    wait_idle(2000);
    chk("bp_stb_cnt", 32'(n_stb - s0), 32'd3);
    chk("bp_rx_q_empty", 32'(exp_rx_q.size()), 32'd0);
    chk("bp_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);

    // Reset mid-frame after the 3rd falling edge
    rep_q.push_back(8'hFF);
    s0 = n_stb;
    send(8'h5A);
    f0 = falls;
    n  = 0;
    while (falls < f0 + 3 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort_falls_seen", 32'(falls - f0), 32'd3);
    rst = 1'b1;
    tick();
    chk("abort_csn", 32'(spi_csn), 32'd1);
    chk("abort_sck", 32'(spi_sck), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_tx_ready", 32'(tx_ready), 32'd1);
    rst = 1'b0;
    repeat (4 * CD + 4) tick();
    chk("abort_no_stb", 32'(n_stb - s0), 32'd0);

    // New frame after abort: C3 / 96
    rep_q.push_back(8'h96);
    exp_tx_q.push_back(8'hC3);
    exp_rx_q.push_back(8'h96);
    s0 = n_stb;
    send(8'hC3);
    wait_frame_end(800);
    chk("post_csn_low", 32'(csn_low), 32'(18 * CD));
    wait_idle(400);
    chk("post_stb_cnt", 32'(n_stb - s0), 32'd1);
    chk("post_rx_hold", 32'(rx_data), 32'h96);
    chk("post_rx_q_empty", 32'(exp_rx_q.size()), 32'd0);
    chk("post_tx_q_empty", 32'(exp_tx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
